// File: rtl/arbiter_requester_if.sv
// Requester-side bundle: command push port, arbiter request/grant pair and status.
// master: the requester agent. slave: whatever drives commands and grants it.
interface arbiter_requester_if #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned LEN_W = 4
);
    localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

    logic             cmd_valid;
    logic [LEN_W-1:0] cmd_len;
    logic             cmd_ready;
    logic             r;
    logic             g;
    logic             busy;
    logic             beat;
    logic             done;
    logic             timeout_err;
    logic             protocol_err;
    logic [LVL_W-1:0] level;

    modport master (
        input  cmd_valid, cmd_len, g,
        output cmd_ready, r, busy, beat, done, timeout_err, protocol_err, level
    );

    modport slave (
        output cmd_valid, cmd_len, g,
        input  cmd_ready, r, busy, beat, done, timeout_err, protocol_err, level
    );
endinterface

// File: rtl/arbiter_requester.sv
// Client-side agent for one round-robin arbiter slot. Queues burst commands,
// requests the arbiter, counts granted beats and releases the request after the
// last beat. Define REQUESTER_ASSERT_EN to compile the built-in protocol assertions.
module arbiter_requester #(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned LEN_W   = 4,
    parameter int unsigned TIMEOUT = 64
) (
    input logic                 clock,
    input logic                 reset,
    arbiter_requester_if.master bus
);
    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned LVL_W  = $clog2(DEPTH) + 1;
    localparam int unsigned WAIT_W = $clog2(TIMEOUT);

    typedef enum logic [1:0] {st_idle, st_req, st_own, st_gap} state_t;

    logic [LEN_W-1:0]  mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0]  level_q;
    logic              full, push, pop;

    state_t            state_q, state_d;
    logic              r_q, r_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic              perr_q;
    logic              beat_c, done_c, tout_c;

    // Full blocks the push even when the head is popped in the same cycle.
    assign full = (level_q == LVL_W'(DEPTH));
    assign push = bus.cmd_valid && !full;
    assign pop  = done_c;

    // Command storage; entries need no reset, the pointers qualify them.
    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wr_ptr_q] <= bus.cmd_len;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            if (push && !pop) begin
                level_q <= level_q + LVL_W'(1);
            end else if (!push && pop) begin
                level_q <= level_q - LVL_W'(1);
            end
        end
    end

    // Next state, wait/beat counters and per-cycle event pulses.
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        cnt_d   = cnt_q;
        beat_c  = 1'b0;
        done_c  = 1'b0;
        tout_c  = 1'b0;
        unique case (state_q)
            st_idle: begin
                wait_d = '0;
                if (level_q != '0) begin
                    state_d = st_req;
                end
            end
            st_req: begin
                // Saturating so a long wait can never wrap back below the limit.
                if (wait_q != '1) begin
                    wait_d = wait_q + WAIT_W'(1);
                end
                if (bus.g) begin
                    state_d = st_own;
                    cnt_d   = mem_q[rd_ptr_q];
                end else if (wait_q == WAIT_W'(TIMEOUT - 1)) begin
                    // Head command stays queued and is retried after the gap.
                    tout_c  = 1'b1;
                    state_d = st_gap;
                end
            end
            st_own: begin
                // A dropped grant just stalls; the request is held.
                if (bus.g) begin
                    beat_c = 1'b1;
                    if (cnt_q == '0) begin
                        done_c  = 1'b1;
                        state_d = st_gap;
                    end else begin
                        cnt_d = cnt_q - LEN_W'(1);
                    end
                end
            end
            st_gap: begin
                // The arbiter's lagging grant lands here and is ignored.
                state_d = st_idle;
            end
            default: begin
                state_d = st_idle;
            end
        endcase
        r_d = (state_d == st_req) || (state_d == st_own);
    end

    // State register; r is registered from the next-state decode.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= st_idle;
            r_q     <= 1'b0;
            wait_q  <= '0;
            cnt_q   <= '0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            wait_q  <= wait_d;
            cnt_q   <= cnt_d;
            if (state_q == st_idle && bus.g) begin
                perr_q <= 1'b1;
            end
        end
    end

    assign bus.cmd_ready    = !full;
    assign bus.r            = r_q;
    assign bus.busy         = (state_q == st_own);
    assign bus.beat         = beat_c;
    assign bus.done         = done_c;
    assign bus.timeout_err  = tout_c;
    assign bus.protocol_err = perr_q;
    assign bus.level        = level_q;

`ifdef REQUESTER_ASSERT_EN
    a_r_held: assert property (@(posedge clock) disable iff (reset)
        (state_q == st_req || state_q == st_own) |-> r_q)
        else $error("r low while in REQ/OWN");

    a_beat_granted: assert property (@(posedge clock) disable iff (reset)
        bus.beat |-> (bus.g && bus.busy))
        else $error("beat without grant in OWN");

    a_done_beat: assert property (@(posedge clock) disable iff (reset)
        bus.done |-> bus.beat)
        else $error("done without beat");

    a_done_tout_excl: assert property (@(posedge clock) disable iff (reset)
        !(bus.done && bus.timeout_err))
        else $error("done and timeout_err together");

    a_level_bound: assert property (@(posedge clock) disable iff (reset)
        bus.level <= LVL_W'(DEPTH))
        else $error("level exceeds DEPTH");

    a_rise_hold: assert property (@(posedge clock) disable iff (reset)
        $rose(r_q) |=> (r_q || $past(tout_c)))
        else $error("r pulse shorter than 2 cycles");
`endif
endmodule

// File: tb/tb_arbiter_requester.sv
// Self-checking bench for arbiter_requester: an arbiter model that echoes r as g
// one cycle later, and a scoreboard of queued burst lengths checked on done.
module tb_arbiter_requester;
    localparam int unsigned DEPTH   = 4;
    localparam int unsigned LEN_W   = 4;
    localparam int unsigned TIMEOUT = 8;

    logic clock = 1'b0;
    logic reset = 1'b1;

    arbiter_requester_if #(.DEPTH(DEPTH), .LEN_W(LEN_W)) bus ();

    arbiter_requester #(
        .DEPTH   (DEPTH),
        .LEN_W   (LEN_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    bit             rst     = 1'b1;
    bit             cv      = 1'b0;
    bit             g_allow = 1'b0;
    bit             g_force = 1'b0;
    logic [LEN_W-1:0] cl    = '0;

    bit  r_prev      = 1'b0;
    bit  seen_rise   = 1'b0;
    int  model_lvl   = 0;
    int  exp_q[$];
    int  beats_cnt   = 0;
    int  r_low_run   = 0;
    int  bursts_done = 0;
    int  timeouts    = 0;
    int  lens[5]     = '{1, 0, 3, 2, 5};

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // One clock: drive inputs just after the edge, sample settled outputs, update model.
    task automatic cycle();
        int e;
        bit pushed;
        @(posedge clock);
        #1;
        cyc++;
        reset         = rst;
        bus.g         = g_force | (g_allow & r_prev);
        bus.cmd_valid = cv;
        bus.cmd_len   = cl;
        #1;
        if (rst) begin
            model_lvl = 0;
            exp_q.delete();
            beats_cnt = 0;
            r_low_run = 0;
            seen_rise = 1'b0;
            r_prev    = 1'b0;
            return;
        end
        check("cmd_ready", int'(bus.cmd_ready), int'(model_lvl != DEPTH));
        check("level", int'(bus.level), model_lvl);
        pushed = cv && (model_lvl != DEPTH);
        if (pushed) exp_q.push_back(int'(cl));
        if (bus.beat) begin
            beats_cnt++;
            check("beat_busy", int'(bus.busy), 1);
        end
        if (bus.done) begin
            if (exp_q.size() == 0) begin
                check("done_unexpected", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("burst_beats", beats_cnt, e + 1);
            end
            beats_cnt = 0;
            bursts_done++;
        end
        if (bus.timeout_err) timeouts++;
        if (bus.r && !r_prev) begin
            if (seen_rise) check("r_low_gap", int'(r_low_run >= 2), 1);
            seen_rise = 1'b1;
        end
        r_low_run = bus.r ? 0 : r_low_run + 1;
        model_lvl = model_lvl + int'(pushed) - int'(bus.done);
        r_prev    = bus.r;
    endtask

    initial begin
        int t0, first_r, first_beat, rhigh, found, n, low, lvl_at, base, nb, stall, tbase;
        bus.g = 1'b0; bus.cmd_valid = 1'b1; bus.cmd_len = 4'd3;

        // Reset held two cycles with a command offered.
        rst = 1'b1; cv = 1'b1; cl = 4'd3;
        cycle(); cycle();
        rst = 1'b0; cv = 1'b0;
        cycle();
        check("rst_r", int'(bus.r), 0);
        check("rst_level", int'(bus.level), 0);
        check("rst_ready", int'(bus.cmd_ready), 1);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_perr", int'(bus.protocol_err), 0);
        check("rst_tout", int'(bus.timeout_err), 0);

        // Single burst of 3 beats, arbiter granting immediately.
        g_allow = 1'b1; cl = 4'd2; cv = 1'b1;
        cycle();
        t0 = cyc; cv = 1'b0;
        first_r = -1; first_beat = -1; rhigh = 0; found = 0;
        for (int i = 0; i < 30 && found == 0; i++) begin
            cycle();
            if (bus.r) rhigh++;
            if (bus.r && first_r < 0) first_r = cyc;
            if (bus.beat && first_beat < 0) first_beat = cyc;
            if (bus.done) found = 1;
        end
        check("t2_done_seen", found, 1);
        check("t2_lat_r", first_r - t0, 2);
        check("t2_lat_beat", first_beat - t0, 4);
        check("t2_r_high", rhigh, 5);
        cycle();
        check("t2_gap_r", int'(bus.r), 0);
        check("t2_level", int'(bus.level), 0);

        // Fill the FIFO; the fifth command must be refused.
        cycle(); cycle();
        g_allow = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cl = LEN_W'(lens[i]); cv = 1'b1;
            cycle();
        end
        check("t3_full_ready", int'(bus.cmd_ready), 0);
        check("t3_full_level", int'(bus.level), 4);
        cv = 1'b0; g_allow = 1'b1;
        base = bursts_done; tbase = timeouts;
        for (int i = 0; i < 200 && bursts_done < base + 4; i++) cycle();
        check("t3_bursts", bursts_done - base, 4);
        check("t3_no_tout", timeouts - tbase, 0);
        cycle();
        check("t3_level", int'(bus.level), 0);

        // Timeout with no grant, then retry of the same head command.
        cycle(); cycle();
        g_allow = 1'b0; cl = 4'd0; cv = 1'b1;
        cycle();
        cv = 1'b0; tbase = timeouts;
        n = 0; found = 0; lvl_at = -1;
        for (int i = 0; i < 40 && found == 0; i++) begin
            cycle();
            if (bus.r) n++;
            if (bus.timeout_err) begin found = 1; lvl_at = int'(bus.level); end
        end
        check("t4_tout_seen", found, 1);
        check("t4_r_high", n, int'(TIMEOUT));
        check("t4_level_at", lvl_at, 1);
        low = 0; found = 0;
        for (int i = 0; i < 6 && found == 0; i++) begin
            cycle();
            if (bus.r) found = 1; else low++;
        end
        check("t4_retry", found, 1);
        check("t4_retry_low", int'(low >= 1 && low <= 2), 1);
        check("t4_retry_level", int'(bus.level), 1);
        g_allow = 1'b1; base = bursts_done;
        for (int i = 0; i < 20 && bursts_done == base; i++) cycle();
        check("t4_done", bursts_done - base, 1);
        check("t4_tout_count", timeouts - tbase, 1);

        // Grant dropped for two cycles mid-burst.
        cycle(); cycle();
        g_allow = 1'b1; cl = 4'd3; cv = 1'b1;
        cycle();
        cv = 1'b0; nb = 0; stall = 0; found = 0;
        for (int i = 0; i < 40 && found == 0; i++) begin
            cycle();
            if (stall > 0) begin
                check("t5_stall_r", int'(bus.r), 1);
                check("t5_stall_beat", int'(bus.beat), 0);
                check("t5_stall_busy", int'(bus.busy), 1);
                stall--;
                if (stall == 0) g_allow = 1'b1;
            end
            if (bus.beat) nb++;
            if (bus.beat && nb == 2) begin g_allow = 1'b0; stall = 2; end
            if (bus.done) begin found = 1; check("t5_beats", nb, 4); end
        end
        check("t5_done_seen", found, 1);

        // Grant while idle sets the sticky protocol error.
        cycle(); cycle(); cycle();
        check("t6_perr_pre", int'(bus.protocol_err), 0);
        g_force = 1'b1;
        cycle();
        g_force = 1'b0;
        cycle();
        check("t6_perr_set", int'(bus.protocol_err), 1);
        cycle(); cycle(); cycle();
        check("t6_perr_sticky", int'(bus.protocol_err), 1);

        // Reset in the middle of a burst.
        g_allow = 1'b1; cl = 4'd7; cv = 1'b1;
        cycle();
        cv = 1'b0; found = 0;
        for (int i = 0; i < 10 && found == 0; i++) begin
            cycle();
            if (bus.busy) found = 1;
        end
        check("t7_own_seen", found, 1);
        cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        cycle();
        check("t7_r", int'(bus.r), 0);
        check("t7_busy", int'(bus.busy), 0);
        check("t7_level", int'(bus.level), 0);
        check("t7_perr", int'(bus.protocol_err), 0);
        cycle(); cycle();
        check("t7_idle_r", int'(bus.r), 0);

        check("end_queue", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
